rat_mul_arb: RTL and testbench
==============================

RAT_MUL_ARB -- requirements
Module: rat_mul_arb

Interface
REQ-001 Parameter WIDTH, default 32: bit width of every numerator, denominator and product field.
REQ-002 Parameter MUL_LAT, default 1: register stages in the external rat_mul multiplier (range 1-7).
REQ-003 clk  input  1  single clock; every register updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-005 req{0,1}_valid  input  1  requester N presents an operand pair.
REQ-006 req{0,1}_ready  output  1  arbiter accepts requester N's operands this cycle.
REQ-007 req{0,1}_l_num, _l_den, _r_num, _r_den  input  WIDTH each  requester N's operands.
REQ-008 rsp{0,1}_valid  output  1  a result for requester N is available.
REQ-009 rsp{0,1}_ready  input  1  requester N takes the result.
REQ-010 rsp{0,1}_num, rsp{0,1}_den  output  WIDTH each  product numerator and denominator.
REQ-011 rsp{0,1}_err  output  1  a zero denominator was present in the accepted operands.
REQ-012 mul_l_num, mul_l_den, mul_r_num, mul_r_den  output  WIDTH each  registered operands to the shared rat_mul.
REQ-013 mul_s_num, mul_s_den  input  WIDTH each  shared rat_mul outputs.
REQ-014 busy  output  1  high whenever the state is not IDLE.

Function
REQ-015 The block SHALL implement states IDLE, MUL and DONE, with at most one operation outstanding.
REQ-016 In IDLE, the granted requester SHALL be the only valid requester, or the round-robin pointer's requester when both are valid.
REQ-017 reqN_ready SHALL be combinational: high only in IDLE, only for the granted N, and only while reqN_valid is high.
REQ-018 On accept (valid and ready at an edge), the block SHALL register the operands onto mul_*, store the grant id, load cnt with MUL_LAT, and enter MUL.
REQ-019 On the same accept edge, the block SHALL register err = (l_den == 0) or (r_den == 0).
REQ-020 In MUL, cnt SHALL decrement each cycle; the edge at which cnt equals 0 SHALL capture mul_s_num/mul_s_den into the result registers and enter DONE.
REQ-021 Latency: rspN_valid SHALL rise exactly MUL_LAT+1 edges after the accept edge.
REQ-022 mul_* operands SHALL stay stable from accept until DONE is exited.
REQ-023 In DONE, only the granted rspN_valid SHALL be high; num, den and err SHALL hold stable until rspN_ready.
REQ-024 On the rsp handshake edge, the block SHALL return to IDLE and set the pointer to the requester other than the one just served.
REQ-025 A new request SHALL be accepted no earlier than the cycle after the rsp handshake; there is no back-to-back overlap.
REQ-026 Products SHALL be the WIDTH LSBs delivered by the multiplier; the arbiter performs no arithmetic and no reduction.
REQ-027 rspN_ready while rspN_valid is low SHALL have no effect; reqN_valid outside IDLE SHALL be ignored and not queued.
REQ-028 A requester dropping valid before being granted SHALL cause no accept and no state change.
REQ-029 A zero denominator SHALL NOT block the operation; the product is still returned with err = 1.

Reset
REQ-030 While rst is high at an edge, the block SHALL set state to IDLE, pointer to 0, cnt to 0, and clear all result and mul_* registers.
REQ-031 After reset, all rsp*_valid, rsp*_err, req*_ready and busy outputs SHALL read 0 (req*_ready may rise combinationally once rst is low).
REQ-032 Reset asserted in MUL or DONE SHALL discard the in-flight operation, and no response SHALL be issued for it.

Verification
REQ-033 Single request: req0 (3/4)*(5/7), MUL_LAT=1 -> rsp0_valid rises 2 edges after accept with num=15, den=28, err=0; rsp1_valid stays 0.
REQ-034 Contention: both valid out of reset -> req0 served first; with both still valid, req1 granted next -> grants alternate 0,1,0,1.
REQ-035 Backpressure: hold rsp1_ready=0 for 10 cycles -> rsp1 outputs stable, busy=1, req0 not accepted; release -> handshake, then IDLE.
REQ-036 Zero denominator: req1 (2/0)*(3/5) -> rsp1_num=6, den=0, err=1.
REQ-037 Reset in MUL: assert rst 1 cycle after accept -> no rsp_valid ever for that op; pointer=0; a next request proceeds normally.
REQ-038 Overflow: WIDTH=8, (16/1)*(16/1) -> num=0x00 (truncated), den=1, err=0.

Source files
------------

// File: rtl/rat_mul_arb.sv
// rat_mul_arb: two-requester round-robin front end for one shared rational multiplier.
//   clk, rst                   : clock, synchronous active-high reset
//   reqN_valid/ready, reqN_*   : operand handshake and operands for requester N
//   rspN_valid/ready           : result handshake for requester N
//   rspN_num/den/err           : product and zero-denominator flag
//   mul_l_*/mul_r_*            : registered operands driven to the external multiplier
//   mul_s_num/den              : external multiplier product, MUL_LAT cycles after the operands
//   busy                       : an operation is in flight or waiting to be taken
module rat_mul_arb #(
   parameter int WIDTH   = 32,
   parameter int MUL_LAT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_l_num,
   input  logic [WIDTH-1:0] req0_l_den,
   input  logic [WIDTH-1:0] req0_r_num,
   input  logic [WIDTH-1:0] req0_r_den,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_l_num,
   input  logic [WIDTH-1:0] req1_l_den,
   input  logic [WIDTH-1:0] req1_r_num,
   input  logic [WIDTH-1:0] req1_r_den,
   output logic             rsp0_valid,
   input  logic             rsp0_ready,
   output logic [WIDTH-1:0] rsp0_num,
   output logic [WIDTH-1:0] rsp0_den,
   output logic             rsp0_err,
   output logic             rsp1_valid,
   input  logic             rsp1_ready,
   output logic [WIDTH-1:0] rsp1_num,
   output logic [WIDTH-1:0] rsp1_den,
   output logic             rsp1_err,
   output logic [WIDTH-1:0] mul_l_num,
   output logic [WIDTH-1:0] mul_l_den,
   output logic [WIDTH-1:0] mul_r_num,
   output logic [WIDTH-1:0] mul_r_den,
   input  logic [WIDTH-1:0] mul_s_num,
   input  logic [WIDTH-1:0] mul_s_den,
   output logic             busy
);
   typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
   state_t state, state_nx;
   logic ptr, gid, err_r, grant, acc, hs, mul_end;
   logic [2:0] cnt;
   logic [WIDTH-1:0] res_num, res_den;
   always_comb begin
      grant    = (req0_valid && req1_valid) ? ptr : req1_valid;
      acc      = state == IDLE && (req0_valid || req1_valid);
      mul_end  = state == MUL && cnt == 3'd0;
      hs       = state == DONE && (gid ? rsp1_ready : rsp0_ready);
      state_nx = acc ? MUL : mul_end ? DONE : hs ? IDLE : state;
   end
   always_ff @(posedge clk)
      if (rst) state <= IDLE;
      else     state <= state_nx;
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr       <= 1'b0;
         gid       <= 1'b0;
         cnt       <= 3'd0;
         err_r     <= 1'b0;
         res_num   <= '0;
         res_den   <= '0;
         mul_l_num <= '0;
         mul_l_den <= '0;
         mul_r_num <= '0;
         mul_r_den <= '0;
      end else begin
         if (acc) begin
            gid       <= grant;
            cnt       <= 3'(MUL_LAT);
            mul_l_num <= grant ? req1_l_num : req0_l_num;
            mul_l_den <= grant ? req1_l_den : req0_l_den;
            mul_r_num <= grant ? req1_r_num : req0_r_num;
            mul_r_den <= grant ? req1_r_den : req0_r_den;
            err_r     <= grant ? (req1_l_den == '0 || req1_r_den == '0)
                               : (req0_l_den == '0 || req0_r_den == '0);
         end
         if (state == MUL && cnt != 3'd0) cnt <= cnt - 3'd1;
         if (mul_end) begin
            res_num <= mul_s_num;
            res_den <= mul_s_den;
         end
         if (hs) ptr <= ~gid;
      end
   end
   assign req0_ready = state == IDLE && !grant && req0_valid;
   assign req1_ready = state == IDLE && grant && req1_valid;
   assign rsp0_valid = state == DONE && !gid;
   assign rsp1_valid = state == DONE && gid;
   assign rsp0_err   = rsp0_valid && err_r;
   assign rsp1_err   = rsp1_valid && err_r;
   assign rsp0_num   = res_num;
   assign rsp0_den   = res_den;
   assign rsp1_num   = res_num;
   assign rsp1_den   = res_den;
   assign busy       = state != IDLE;
endmodule

// File: tb/tb_rat_mul_arb.sv
// tb_rat_mul_arb: scoreboard bench for rat_mul_arb with behavioural multiplier models.
module tb_rat_mul_arb;
   localparam int W = 32, LAT = 1, BW = 8, BLAT = 3;
   logic clk = 1'b0, rst = 1'b1;
   always #5 clk = ~clk;

   logic req0_valid, req1_valid, rsp0_ready, rsp1_ready;
   logic [W-1:0] req0_l_num, req0_l_den, req0_r_num, req0_r_den;
   logic [W-1:0] req1_l_num, req1_l_den, req1_r_num, req1_r_den;
   logic req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err, busy;
   logic [W-1:0] rsp0_num, rsp0_den, rsp1_num, rsp1_den;
   logic [W-1:0] mul_l_num, mul_l_den, mul_r_num, mul_r_den, mul_s_num, mul_s_den;

   logic b_req0_valid, b_req1_valid, b_rsp0_ready, b_rsp1_ready;
   logic [BW-1:0] b_req0_l_num, b_req0_l_den, b_req0_r_num, b_req0_r_den;
   logic [BW-1:0] b_req1_l_num, b_req1_l_den, b_req1_r_num, b_req1_r_den;
   logic b_req0_ready, b_req1_ready, b_rsp0_valid, b_rsp1_valid, b_rsp0_err, b_rsp1_err, b_busy;
   logic [BW-1:0] b_rsp0_num, b_rsp0_den, b_rsp1_num, b_rsp1_den;
   logic [BW-1:0] b_mul_l_num, b_mul_l_den, b_mul_r_num, b_mul_r_den;
   logic [BW-1:0] bpn [BLAT], bpd [BLAT];

   rat_mul_arb #(.WIDTH(W), .MUL_LAT(LAT)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req0_l_num(req0_l_num), .req0_l_den(req0_l_den), .req0_r_num(req0_r_num), .req0_r_den(req0_r_den),
      .req1_valid(req1_valid), .req1_ready(req1_ready),
      .req1_l_num(req1_l_num), .req1_l_den(req1_l_den), .req1_r_num(req1_r_num), .req1_r_den(req1_r_den),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_num(rsp0_num), .rsp0_den(rsp0_den), .rsp0_err(rsp0_err),
      .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_num(rsp1_num), .rsp1_den(rsp1_den), .rsp1_err(rsp1_err),
      .mul_l_num(mul_l_num), .mul_l_den(mul_l_den), .mul_r_num(mul_r_num), .mul_r_den(mul_r_den),
      .mul_s_num(mul_s_num), .mul_s_den(mul_s_den), .busy(busy));

   rat_mul_arb #(.WIDTH(BW), .MUL_LAT(BLAT)) dut_b (
      .clk(clk), .rst(rst),
      .req0_valid(b_req0_valid), .req0_ready(b_req0_ready),
      .req0_l_num(b_req0_l_num), .req0_l_den(b_req0_l_den), .req0_r_num(b_req0_r_num), .req0_r_den(b_req0_r_den),
      .req1_valid(b_req1_valid), .req1_ready(b_req1_ready),
      .req1_l_num(b_req1_l_num), .req1_l_den(b_req1_l_den), .req1_r_num(b_req1_r_num), .req1_r_den(b_req1_r_den),
      .rsp0_valid(b_rsp0_valid), .rsp0_ready(b_rsp0_ready), .rsp0_num(b_rsp0_num), .rsp0_den(b_rsp0_den), .rsp0_err(b_rsp0_err),
      .rsp1_valid(b_rsp1_valid), .rsp1_ready(b_rsp1_ready), .rsp1_num(b_rsp1_num), .rsp1_den(b_rsp1_den), .rsp1_err(b_rsp1_err),
      .mul_l_num(b_mul_l_num), .mul_l_den(b_mul_l_den), .mul_r_num(b_mul_r_num), .mul_r_den(b_mul_r_den),
      .mul_s_num(bpn[BLAT-1]), .mul_s_den(bpd[BLAT-1]), .busy(b_busy));

   // external multipliers: one stage for the wide instance, three for the narrow one
   always @(posedge clk) begin
      mul_s_num <= mul_l_num * mul_r_num;
      mul_s_den <= mul_l_den * mul_r_den;
      bpn[0] <= b_mul_l_num * b_mul_r_num;
      bpd[0] <= b_mul_l_den * b_mul_r_den;
      for (int i = 1; i < BLAT; i++) begin
         bpn[i] <= bpn[i-1];
         bpd[i] <= bpd[i-1];
      end
   end

   typedef struct packed {logic id; logic [31:0] num; logic [31:0] den; logic err;} exp_t;
   exp_t qa[$], qb[$];
   int pass_n = 0, tot_n = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tot_n++;
      if (act === exp) pass_n++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic fail(input string name);
      tot_n++;
      $display("FAIL %s: timed out", name);
   endtask

   task automatic pop_chk(inout exp_t q[$], input string tag, input logic id,
                          input logic [31:0] num, input logic [31:0] den, input logic err);
      exp_t e;
      if (q.size() == 0) begin
         chk({tag, " unexpected rsp"}, 1, 0);
      end else begin
         e = q.pop_front();
         chk({tag, " rsp id"}, id, e.id);
         chk({tag, " rsp num"}, num, e.num);
         chk({tag, " rsp den"}, den, e.den);
         chk({tag, " rsp err"}, err, e.err);
      end
   endtask

   // monitor: every response handshake is compared against the scoreboard head
   always @(negedge clk) if (!rst) begin
      if (rsp0_valid && rsp0_ready) pop_chk(qa, "A", 1'b0, rsp0_num, rsp0_den, rsp0_err);
      if (rsp1_valid && rsp1_ready) pop_chk(qa, "A", 1'b1, rsp1_num, rsp1_den, rsp1_err);
      if (b_rsp0_valid && b_rsp0_ready) pop_chk(qb, "B", 1'b0, 32'(b_rsp0_num), 32'(b_rsp0_den), b_rsp0_err);
      if (b_rsp1_valid && b_rsp1_ready) pop_chk(qb, "B", 1'b1, 32'(b_rsp1_num), 32'(b_rsp1_den), b_rsp1_err);
   end

   task automatic set_ops(input logic id, input logic [31:0] ln, ld, rn, rd);
      if (id) begin
         req1_l_num = ln; req1_l_den = ld; req1_r_num = rn; req1_r_den = rd; req1_valid = 1'b1;
      end else begin
         req0_l_num = ln; req0_l_den = ld; req0_r_num = rn; req0_r_den = rd; req0_valid = 1'b1;
      end
   endtask

   task automatic wait_grant(output logic g);
      int t = 0;
      while (!(req0_ready || req1_ready) && t < 50) begin
         @(negedge clk); #1; t++;
      end
      if (t >= 50) fail("grant");
      g = req1_ready;
   endtask

   // present one request, wait for accept, optionally score it; returns just after the accept edge
   task automatic issue(input logic id, input logic [31:0] ln, ld, rn, rd, en, ed, input logic ee, input bit push);
      logic g;
      @(negedge clk);
      set_ops(id, ln, ld, rn, rd);
      #1;
      wait_grant(g);
      chk("grant id", g, id);
      if (push) qa.push_back('{id, en, ed, ee});
      @(posedge clk); #1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
   endtask

   task automatic wait_rsp(input logic id);
      int lat = 0;
      do begin
         @(posedge clk); #1; lat++;
      end while (!(id ? rsp1_valid : rsp0_valid) && lat < 50);
      chk("latency", lat, LAT + 1);
      chk("other rsp idle", id ? rsp0_valid : rsp1_valid, 0);
   endtask

   task automatic wait_idle();
      int t = 0;
      @(negedge clk);
      while (busy && t < 100) begin
         @(negedge clk); t++;
      end
      if (t >= 100) fail("idle");
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $display("%0d/%0d checks passed", pass_n, tot_n + 1);
      $fatal(1);
   end

   initial begin
      logic g;
      logic [31:0] n, d;
      int lat;
      req0_valid = 0; req1_valid = 0; rsp0_ready = 1; rsp1_ready = 1;
      {req0_l_num, req0_l_den, req0_r_num, req0_r_den} = '0;
      {req1_l_num, req1_l_den, req1_r_num, req1_r_den} = '0;
      b_req0_valid = 0; b_req1_valid = 0; b_rsp0_ready = 1; b_rsp1_ready = 1;
      {b_req0_l_num, b_req0_l_den, b_req0_r_num, b_req0_r_den} = '0;
      {b_req1_l_num, b_req1_l_den, b_req1_r_num, b_req1_r_den} = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset busy", busy, 0);
      chk("reset rsp0_valid", rsp0_valid, 0);
      chk("reset rsp1_valid", rsp1_valid, 0);
      chk("reset rsp0_err", rsp0_err, 0);
      chk("reset rsp1_err", rsp1_err, 0);
      chk("reset req ready", {req0_ready, req1_ready}, 0);
      chk("reset mul_l_num", mul_l_num, 0);
      chk("reset mul_r_den", mul_r_den, 0);
      rst = 0;

      // contention: both held valid, grants alternate starting with requester 0
      @(negedge clk);
      set_ops(0, 1, 2, 3, 4);
      set_ops(1, 5, 6, 7, 8);
      #1;
      for (int k = 0; k < 4; k++) begin
         wait_grant(g);
         chk("contention grant order", g, k % 2);
         if (g) qa.push_back('{1'b1, 32'd35, 32'd48, 1'b0});
         else   qa.push_back('{1'b0, 32'd3, 32'd8, 1'b0});
         @(posedge clk);
         wait_idle();
         #1;
      end
      req0_valid = 0; req1_valid = 0;

      // single request (3/4)*(5/7)
      issue(0, 3, 4, 5, 7, 15, 28, 0, 1);
      wait_rsp(0);
      wait_idle();

      // backpressure on rsp1 with req0 waiting, then req0 withdrawn before release
      rsp1_ready = 0;
      issue(1, 5, 6, 7, 8, 35, 48, 0, 1);
      wait_rsp(1);
      n = rsp1_num; d = rsp1_den;
      @(negedge clk);
      set_ops(0, 1, 1, 1, 1);
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         chk("bp rsp1 held", {rsp1_valid, rsp1_num, rsp1_den}, {1'b1, n, d});
         chk("bp busy", busy, 1);
         chk("bp req0_ready", req0_ready, 0);
      end
      req0_valid = 0;
      rsp1_ready = 1;
      wait_idle();
      repeat (3) begin
         @(negedge clk);
         chk("withdrawn req not queued", busy, 0);
      end

      // zero denominator still produces a product, flagged
      issue(1, 2, 0, 3, 5, 6, 0, 1, 1);
      wait_rsp(1);
      wait_idle();

      // plain req0 leaves the pointer on requester 1
      issue(0, 2, 3, 4, 5, 8, 15, 0, 1);
      wait_rsp(0);
      wait_idle();

      // reset one cycle after accept discards the operation and the pointer
      issue(1, 9, 1, 9, 1, 0, 0, 0, 0);
      rst = 1;
      @(posedge clk); #1;
      rst = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         chk("no rsp after reset", {rsp0_valid, rsp1_valid, busy}, 0);
      end
      set_ops(0, 1, 3, 1, 3);
      set_ops(1, 2, 2, 2, 2);
      #1;
      wait_grant(g);
      chk("pointer reset grant", g, 0);
      qa.push_back('{1'b0, 32'd1, 32'd9, 1'b0});
      @(posedge clk); #1;
      req0_valid = 0; req1_valid = 0;
      wait_rsp(0);
      wait_idle();

      // narrow instance: (16/1)*(16/1) truncates to 0/1, latency BLAT+1
      @(negedge clk);
      b_req0_l_num = 16; b_req0_l_den = 1; b_req0_r_num = 16; b_req0_r_den = 1; b_req0_valid = 1;
      #1;
      lat = 0;
      while (!b_req0_ready && lat < 50) begin
         @(negedge clk); #1; lat++;
      end
      if (lat >= 50) fail("B accept");
      qb.push_back('{1'b0, 32'd0, 32'd1, 1'b0});
      @(posedge clk); #1;
      b_req0_valid = 0;
      lat = 0;
      do begin
         @(posedge clk); #1; lat++;
      end while (!b_rsp0_valid && lat < 50);
      chk("B latency", lat, BLAT + 1);
      lat = 0;
      while (b_busy && lat < 50) begin
         @(negedge clk); lat++;
      end
      if (lat >= 50) fail("B idle");

      repeat (3) @(negedge clk);
      chk("scoreboard A drained", qa.size(), 0);
      chk("scoreboard B drained", qb.size(), 0);
      $display("%0d/%0d checks passed", pass_n, tot_n);
      $finish;
   end
endmodule
